// File: rtl/mode_arb_pkg.sv
// Shared types and helpers for the mode arbiter and its debounce stage.
package mode_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    MUTE   = 2'd2,
    ACTIVE = 2'd3
  } arb_state_e;

  localparam int NOTE_SILENT = 0;

  // True when exactly one bit of x is set; zero and multi-hot are rejected.
  function automatic logic onehot_valid(input logic [31:0] x);
    return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
  endfunction

  // Counter width able to reach the larger of two limits without wrapping.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/mode_arbiter_debounce.sv
// Candidate register plus stability counter for the mode switch bus.
// 'load' captures a fresh candidate; while 'run' is high the counter advances
// on every cycle the bus still matches, and 'accept' pulses for one cycle once
// the candidate has held long enough.
module mode_debounce
  import mode_arb_pkg::*;
#(
  parameter int NUM_MODES     = 3,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = cnt_width(STABLE_CYCLES, STABLE_CYCLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 run,
  input  logic [NUM_MODES-1:0] mode,
  output logic [NUM_MODES-1:0] cand,
  output logic                 accept
);

  logic [NUM_MODES-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 match;
  logic                 at_limit;

  assign match    = (mode == cand_q);
  assign at_limit = (cnt_q == CNT_W'(STABLE_CYCLES - 1));
  assign accept   = run && match && at_limit;
  assign cand     = cand_q;

  // Restart on load or on any bounce; otherwise count up, saturating at the limit.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (load || (run && !match)) begin
      cand_d = mode;
      cnt_d  = '0;
    end else if (run && !at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Candidate and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mode_arbiter.sv
// Mode arbiter: picks one engine from a one-hot switch bus, debounces changes,
// inserts a muted gap with a restart pulse, and drives the shared outputs
// through a registered slice mux.
module mode_arbiter
  import mode_arb_pkg::*;
#(
  parameter int NUM_MODES     = 3,
  parameter int NOTE_W        = 4,
  parameter int LED_W         = 7,
  parameter int NUM_W         = 4,
  parameter int OCT_W         = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int MUTE_CYCLES   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_MODES-1:0]        mode,
  input  logic [NUM_MODES*NOTE_W-1:0] note_in,
  input  logic [NUM_MODES*LED_W-1:0]  led_in,
  input  logic [NUM_MODES*NUM_W-1:0]  num_in,
  input  logic [NUM_MODES*OCT_W-1:0]  oct_in,
  output logic [NOTE_W-1:0]           note_out,
  output logic [LED_W-1:0]            led_out,
  output logic [NUM_W-1:0]            num_out,
  output logic [OCT_W-1:0]            octave_out,
  output logic [NUM_MODES-1:0]        src_enable,
  output logic [NUM_MODES-1:0]        src_restart,
  output logic [NUM_MODES-1:0]        active_mode,
  output logic                        switching
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES, MUTE_CYCLES);

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     mute_cnt_q, mute_cnt_d;
  logic [NUM_MODES-1:0] active_q, active_d;
  logic [NUM_MODES-1:0] enable_q, enable_d;
  logic [NUM_MODES-1:0] restart_q, restart_d;
  logic                 switching_q, switching_d;
  logic [NOTE_W-1:0]    note_q, note_d, note_sel;
  logic [LED_W-1:0]     led_q, led_d, led_sel;
  logic [NUM_W-1:0]     num_q, num_d, num_sel;
  logic [OCT_W-1:0]     oct_q, oct_d, oct_sel;

  logic [NUM_MODES-1:0] cand;
  logic                 accept;
  logic                 deb_load;
  logic                 deb_run;
  logic                 live_now;
  logic                 live_next;

  assign deb_run = (state_q == SETTLE);

  mode_debounce #(
    .NUM_MODES     (NUM_MODES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .load   (deb_load),
    .run    (deb_run),
    .mode   (mode),
    .cand   (cand),
    .accept (accept)
  );

  // AND-OR slice mux over the committed mode; an all-zero select yields zero.
  always_comb begin
    note_sel = '0;
    led_sel  = '0;
    num_sel  = '0;
    oct_sel  = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (active_q[i]) begin
        note_sel = note_sel | note_in[i*NOTE_W +: NOTE_W];
        led_sel  = led_sel  | led_in[i*LED_W +: LED_W];
        num_sel  = num_sel  | num_in[i*NUM_W +: NUM_W];
        oct_sel  = oct_sel  | oct_in[i*OCT_W +: OCT_W];
      end
    end
  end

  // Next-state logic: IDLE/ACTIVE watch for a new mode, SETTLE waits for the
  // debouncer's verdict, MUTE counts out the silent gap (mode input ignored).
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    mute_cnt_d = mute_cnt_q;
    restart_d  = '0;
    deb_load   = 1'b0;
    unique case (state_q)
      IDLE, ACTIVE: begin
        if (mode != active_q) begin
          deb_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (accept) begin
          if (!onehot_valid(32'(cand))) begin
            active_d = '0;
            state_d  = IDLE;
          end else if (cand == active_q) begin
            state_d = ACTIVE;
          end else begin
            state_d    = MUTE;
            mute_cnt_d = '0;
            restart_d  = cand;
          end
        end
      end
      MUTE: begin
        if (mute_cnt_q == CNT_W'(MUTE_CYCLES - 1)) begin
          state_d  = ACTIVE;
          active_d = cand;
        end else begin
          mute_cnt_d = mute_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values: the selected engine plays only while it is live before and
  // after this edge, so a mute or drop to IDLE silences from its first cycle.
  always_comb begin
    live_now    = (state_q == SETTLE) || (state_q == ACTIVE);
    live_next   = (state_d == SETTLE) || (state_d == ACTIVE);
    enable_d    = (state_d == MUTE) ? '0 : active_d;
    switching_d = (state_d == SETTLE) || (state_d == MUTE);
    if (live_now && live_next) begin
      note_d = note_sel;
      led_d  = led_sel;
      num_d  = num_sel;
      oct_d  = oct_sel;
    end else begin
      note_d = NOTE_W'(NOTE_SILENT);
      led_d  = '0;
      num_d  = '0;
      oct_d  = oct_q;
    end
  end

  // FSM state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mute_cnt_q  <= '0;
      active_q    <= '0;
      enable_q    <= '0;
      restart_q   <= '0;
      switching_q <= 1'b0;
      note_q      <= '0;
      led_q       <= '0;
      num_q       <= '0;
      oct_q       <= '0;
    end else begin
      state_q     <= state_d;
      mute_cnt_q  <= mute_cnt_d;
      active_q    <= active_d;
      enable_q    <= enable_d;
      restart_q   <= restart_d;
      switching_q <= switching_d;
      note_q      <= note_d;
      led_q       <= led_d;
      num_q       <= num_d;
      oct_q       <= oct_d;
    end
  end

  assign note_out    = note_q;
  assign led_out     = led_q;
  assign num_out     = num_q;
  assign octave_out  = oct_q;
  assign src_enable  = enable_q;
  assign src_restart = restart_q;
  assign active_mode = active_q;
  assign switching   = switching_q;

endmodule

// File: tb/tb_mode_arbiter.sv
// Bench for mode_arbiter: directed scenarios with literal expectations plus a
// long randomized run, all checked every cycle against a behavioural model.
module tb_mode_arbiter;

  localparam int N      = 3;
  localparam int NW     = 4;
  localparam int LW     = 7;
  localparam int UW     = 4;
  localparam int OW     = 2;
  localparam int STABLE = 4;
  localparam int MUTE   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    mode;
  logic [N*NW-1:0] note_in;
  logic [N*LW-1:0] led_in;
  logic [N*UW-1:0] num_in;
  logic [N*OW-1:0] oct_in;
  logic [NW-1:0]   note_out;
  logic [LW-1:0]   led_out;
  logic [UW-1:0]   num_out;
  logic [OW-1:0]   octave_out;
  logic [N-1:0]    src_enable;
  logic [N-1:0]    src_restart;
  logic [N-1:0]    active_mode;
  logic            switching;

  mode_arbiter #(
    .NUM_MODES(N), .NOTE_W(NW), .LED_W(LW), .NUM_W(UW), .OCT_W(OW),
    .STABLE_CYCLES(STABLE), .MUTE_CYCLES(MUTE)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .note_in(note_in), .led_in(led_in), .num_in(num_in), .oct_in(oct_in),
    .note_out(note_out), .led_out(led_out), .num_out(num_out),
    .octave_out(octave_out), .src_enable(src_enable),
    .src_restart(src_restart), .active_mode(active_mode),
    .switching(switching)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit pin5   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The committed mode, the candidate being watched, how many consecutive
  // matching samples it has had, and how many silent cycles remain.
  logic [N-1:0]  m_active = '0;
  logic [N-1:0]  m_cand   = '0;
  int            m_seen   = 0;
  int            m_mute_left = 0;
  bit            m_settling  = 1'b0;

  logic [NW-1:0] e_note = '0;
  logic [LW-1:0] e_led  = '0;
  logic [UW-1:0] e_num  = '0;
  logic [OW-1:0] e_oct  = '0;
  logic [N-1:0]  e_enable = '0, e_restart = '0, e_active = '0;
  bit            e_switching = 1'b0;

  function automatic int src_index(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    bit           live_before, live_after;
    logic [N-1:0] act_before;
    int           src;
    if (reset) begin
      m_active = '0; m_cand = '0; m_seen = 0; m_mute_left = 0; m_settling = 1'b0;
      e_note = '0; e_led = '0; e_num = '0; e_oct = '0;
      e_enable = '0; e_restart = '0; e_active = '0; e_switching = 1'b0;
      return;
    end
    live_before = (m_mute_left == 0) && (m_settling || m_active != '0);
    act_before  = m_active;
    e_restart   = '0;
    if (m_mute_left > 0) begin
      m_mute_left--;
      if (m_mute_left == 0) m_active = m_cand;
    end else if (m_settling) begin
      if (mode != m_cand) begin
        m_cand = mode;
        m_seen = 0;
      end else begin
        m_seen++;
        if (m_seen == STABLE) begin
          m_settling = 1'b0;
          if ($countones(m_cand) != 1) m_active = '0;
          else if (m_cand != m_active) begin
            m_mute_left = MUTE;
            e_restart   = m_cand;
          end
        end
      end
    end else if (mode != m_active) begin
      m_settling = 1'b1;
      m_cand     = mode;
      m_seen     = 0;
    end
    live_after  = (m_mute_left == 0) && (m_settling || m_active != '0);
    e_switching = m_settling || (m_mute_left > 0);
    e_active    = m_active;
    e_enable    = (m_mute_left > 0) ? '0 : m_active;
    src = src_index(act_before);
    if (live_before && live_after && src >= 0) begin
      e_note = note_in[src*NW +: NW];
      e_led  = led_in[src*LW +: LW];
      e_num  = num_in[src*UW +: UW];
      e_oct  = oct_in[src*OW +: OW];
    end else if (live_before && live_after) begin
      e_note = '0; e_led = '0; e_num = '0; e_oct = '0;
    end else begin
      e_note = '0; e_led = '0; e_num = '0;
    end
  endtask

  always @(posedge clk) model_step();

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("note_out",    32'(note_out),    32'(e_note));
      check("led_out",     32'(led_out),     32'(e_led));
      check("num_out",     32'(num_out),     32'(e_num));
      check("octave_out",  32'(octave_out),  32'(e_oct));
      check("src_enable",  32'(src_enable),  32'(e_enable));
      check("src_restart", 32'(src_restart), 32'(e_restart));
      check("active_mode", 32'(active_mode), 32'(e_active));
      check("switching",   32'(switching),   32'(e_switching));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rand_data();
    note_in = 12'($urandom());
    led_in  = 21'($urandom());
    num_in  = 12'($urandom());
    oct_in  = 6'($urandom());
    if (pin5) note_in[NW +: NW] = 4'd5;
  endtask

  task automatic tick();
    @(negedge clk);
    rand_data();
  endtask

  int sw_cnt;
  int bad_cnt;
  int r;

  // ---------------- directed scenarios + random run ----------------
  initial begin
    reset = 1'b1;
    mode  = '0;
    rand_data();
    @(negedge clk);
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // Idle with no switch set: silent and never switching.
    sw_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (switching) sw_cnt++;
    end
    check("idle_sw_cycles", 32'(sw_cnt), 32'd0);
    check("idle_note", 32'(note_out), 32'd0);
    check("idle_active", 32'(active_mode), 32'd0);

    // First selection of source 1.
    pin5 = 1'b1;
    rand_data();
    mode = 3'b010;
    sw_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (switching) sw_cnt++;
      if (k == 4)  check("s2_no_early_restart", 32'(src_restart), 32'd0);
      if (k == 5)  check("s2_restart", 32'(src_restart), 32'b010);
      if (k == 12) check("s2_mute_enable", 32'(src_enable), 32'd0);
      if (k == 13) check("s2_enable", 32'(src_enable), 32'b010);
      if (k == 14) check("s2_note5", 32'(note_out), 32'd5);
    end
    check("s2_sw_cycles", 32'(sw_cnt), 32'd12);

    // Bounce to 001 for two cycles then back: no mute, playback continues.
    mode = 3'b001;
    sw_cnt = 0;
    bad_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) mode = 3'b010;
      if (src_restart != '0) sw_cnt++;
      if (note_out != 4'd5) bad_cnt++;
      if (k == 6) check("s3_settling", 32'(switching), 32'd1);
      if (k == 7) check("s3_back_active", 32'(switching), 32'd0);
    end
    check("s3_restarts", 32'(sw_cnt), 32'd0);
    check("s3_note_breaks", 32'(bad_cnt), 32'd0);
    check("s3_active", 32'(active_mode), 32'b010);

    // Multi-hot settles into IDLE.
    mode = 3'b011;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        check("s4_settle_note", 32'(note_out), 32'd5);
        check("s4_settle_enable", 32'(src_enable), 32'b010);
      end
    end
    check("s4_active", 32'(active_mode), 32'd0);
    check("s4_enable", 32'(src_enable), 32'd0);
    check("s4_note", 32'(note_out), 32'd0);
    check("s4_switching", 32'(switching), 32'd0);
    mode = 3'b000;
    repeat (3) tick();
    check("s4_quiet", 32'(switching), 32'd0);

    // Mode change during MUTE is deferred until the first ACTIVE cycle.
    mode = 3'b100;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k == 7) mode = 3'b001;
      if (k == 5)  check("s5_restart1", 32'(src_restart), 32'b100);
      if (k == 12) check("s5_mute_sw", 32'(switching), 32'd1);
      if (k == 13) begin
        check("s5_active_100", 32'(active_mode), 32'b100);
        check("s5_one_active_cycle", 32'(switching), 32'd0);
        check("s5_note_gap", 32'(note_out), 32'd0);
      end
      if (k == 14) check("s5_resettle", 32'(switching), 32'd1);
      if (k == 18) check("s5_restart2", 32'(src_restart), 32'b001);
      if (k == 26) begin
        check("s5_active_001", 32'(active_mode), 32'b001);
        check("s5_enable_001", 32'(src_enable), 32'b001);
      end
    end

    // Reset in the middle of a mute gap.
    mode = 3'b010;
    for (int k = 1; k <= 5; k++) tick();
    check("s6_in_mute", 32'(switching), 32'd1);
    reset = 1'b1;
    tick();
    check("s6_note", 32'(note_out), 32'd0);
    check("s6_oct", 32'(octave_out), 32'd0);
    check("s6_restart", 32'(src_restart), 32'd0);
    check("s6_enable", 32'(src_enable), 32'd0);
    check("s6_active", 32'(active_mode), 32'd0);
    check("s6_switching", 32'(switching), 32'd0);
    reset = 1'b0;
    mode  = '0;
    pin5  = 1'b0;
    repeat (2) tick();

    // Randomized run: occasional mode changes, bounces and reset pulses.
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = 1'b0;
      r = int'($urandom_range(0, 199));
      if (r < 10)       mode = 3'(1 << $urandom_range(0, 2));
      else if (r < 13)  mode = 3'($urandom_range(0, 7));
      else if (r == 199) reset = 1'b1;
    end
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_arbiter.md
Name: mode_arbiter

Overview:
Parametrised successor to the top-level mode controller. It selects one of NUM_MODES sub-mode engines (free, auto, learn, ...) from a one-hot mode switch bus and drives the shared note, LED, digit and octave outputs through a registered mux. Mode changes are debounced and followed by a muted gap. The incoming engine gets a restart pulse and an enable, so no stale notes leak across a mode change.

Parameters:
NUM_MODES, 3, number of source engines / mode switch bits
NOTE_W, 4, note code width; code 0 = silence
LED_W, 7, LED bus width per source
NUM_W, 4, digit/score width per source
OCT_W, 2, octave width per source
STABLE_CYCLES, 16, cycles the mode bus must hold before it is acted on (>=1)
MUTE_CYCLES, 64, silent cycles inserted on every accepted mode change (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode  in  NUM_MODES  one-hot mode switches; bit i selects source i
note_in  in  NUM_MODES*NOTE_W  flattened per-source notes, source i at [i*NOTE_W +: NOTE_W]
led_in  in  NUM_MODES*LED_W  flattened per-source LED buses
num_in  in  NUM_MODES*NUM_W  flattened per-source digit values
oct_in  in  NUM_MODES*OCT_W  flattened per-source octaves
note_out  out  NOTE_W  selected note, registered
led_out  out  LED_W  selected LEDs, registered
num_out  out  NUM_W  selected digit, registered
octave_out  out  OCT_W  selected octave, registered
src_enable  out  NUM_MODES  one-hot run enable to engines; all-zero when none active
src_restart  out  NUM_MODES  one-cycle restart pulse to the incoming engine
active_mode  out  NUM_MODES  currently committed mode, one-hot or zero
switching  out  1  high in SETTLE and MUTE

Behaviour:
- Reset (sync, active-high, dominates all inputs):
  - state = IDLE; every output = 0.
  - candidate = 0; counter = 0.
- valid(x): exactly one bit of x is set. Zero or multi-hot is invalid.
- IDLE:
  - Outputs silent; src_enable = 0.
  - If mode != active_mode: candidate <= mode, counter <= 0, go to SETTLE.
- SETTLE:
  - If mode != candidate: candidate <= mode, counter <= 0.
  - Otherwise counter++. When counter == STABLE_CYCLES-1 the candidate is accepted:
    - candidate == active_mode and valid: return to ACTIVE, no mute, no restart.
    - candidate valid and different: go to MUTE, counter <= 0.
    - candidate invalid: active_mode <= 0, src_enable <= 0, go to IDLE.
  - The previous engine keeps driving the outputs and stays enabled during SETTLE. Switch bounce therefore never silences playback.
- MUTE:
  - note_out, led_out, num_out = 0; octave_out holds its last value.
  - src_enable = 0.
  - src_restart = candidate for the first MUTE cycle only.
  - After MUTE_CYCLES cycles: active_mode <= candidate, src_enable <= candidate, go to ACTIVE.
  - Mode input changes during MUTE are ignored until ACTIVE. The mismatch is then detected on the first ACTIVE cycle and normal SETTLE follows.
- ACTIVE:
  - Outputs = slice of the selected source, registered: 1-cycle latency from *_in to *_out.
  - If mode != active_mode: go to SETTLE, candidate <= mode, counter <= 0.
- switching = (state == SETTLE) or (state == MUTE).
- Counters are sized $clog2(max(STABLE_CYCLES, MUTE_CYCLES)) + 1 and never wrap.
- No combinational path from any input to any output.

Decomposition:
- Shared package mode_arb_pkg holds:
  - state enum {IDLE, SETTLE, MUTE, ACTIVE};
  - NOTE_SILENT = 0;
  - a function onehot_valid.
- One sub-module, mode_debounce: holds the candidate register and stability counter, and emits a one-cycle accept pulse plus the accepted value.
- Slice mux and FSM stay in mode_arbiter.

Test Plan:
Bench overrides STABLE_CYCLES=4, MUTE_CYCLES=8.
- Reset, mode=3'b000 -> all outputs 0, state IDLE, switching=0 indefinitely.
- From reset, mode=3'b010 held -> switching high 12 cycles; src_restart=3'b010 on the 5th cycle after the change; src_enable=3'b010 after the 12th. With note_in source1 = 4'd5, note_out = 5 one cycle after ACTIVE.
- ACTIVE on 3'b010, mode goes 3'b001 for 2 cycles then back to 3'b010 -> no mute, no restart pulse. note_out tracks source1 throughout and returns to ACTIVE after 4 stable cycles.
- ACTIVE on 3'b010, mode = 3'b011 held -> after 4 cycles active_mode=0, src_enable=0, note_out=0, state IDLE.
- During MUTE toward 3'b100, mode changes to 3'b001 -> MUTE completes and ACTIVE is entered on 3'b100 for one cycle. SETTLE then follows, ending in a second MUTE and ACTIVE on 3'b001.
- Reset asserted mid-MUTE -> on the next edge all outputs 0, src_restart 0, state IDLE.
